// File: rtl/rtc_bus_responder.sv
// Responder for the multiplexed address/data RTC bus: strobe decode, address latch,
// register file with a self-advancing BCD time-of-day, and read-back onto DIR_DATO.
module rtc_bus_responder #(
    parameter int TICK_DIV = 100
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       CS_n,
    input  logic       AD_n,
    input  logic       RD_n,
    input  logic       WR_n,
    inout  wire  [7:0] DIR_DATO,
    output logic       drive_en,
    output logic [7:0] addr_q
);

    // state   | meaning
    // S_IDLE  | no transfer in progress
    // S_ADDR  | address phase, addr latched on WR_n rising edge
    // S_WRITE | data phase, addressed register written on WR_n rising edge
    // S_READ  | addressed register driven onto DIR_DATO
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WRITE, S_READ} state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

    state_t        r_state;
    logic          r_cs_q, r_ad_q, r_rd_q, r_wr_q, r_wr_p;
    logic [7:0]    r_bus_q, r_bus_p;
    logic          r_drive;
    logic [7:0]    r_addr;
    logic [7:0]    r_seg, r_min, r_hora, r_dia, r_mes, r_ano;
    logic [7:0]    r_segcr, r_mincr, r_horacr, r_ctrl;
    logic [PW-1:0] r_presc;

    logic       w_wr_rise, w_wr_en, w_tick, w_c_seg, w_c_min;
    logic [7:0] w_rdata;

    // Out-of-range or non-BCD values wrap to zero with carry, same as the maximum.
    function automatic logic bcd_wrap(input logic [7:0] v, input logic [7:0] vmax);
        return (v >= vmax) || (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
    endfunction

    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] vmax);
        if (bcd_wrap(v, vmax))
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_wr_rise = !r_wr_p && r_wr_q;
    assign w_wr_en   = (r_state == S_WRITE) && !r_cs_q && w_wr_rise;
    assign w_tick    = !r_ctrl[0] && (r_presc == TC);
    assign w_c_seg   = w_tick && bcd_wrap(r_seg, 8'h59);
    assign w_c_min   = w_c_seg && bcd_wrap(r_min, 8'h59);

    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_cs_q  <= 1'b1;
            r_ad_q  <= 1'b1;
            r_rd_q  <= 1'b1;
            r_wr_q  <= 1'b1;
            r_wr_p  <= 1'b1;
            r_bus_q <= 8'h00;
            r_bus_p <= 8'h00;
        end else begin
            r_cs_q  <= CS_n;
            r_ad_q  <= AD_n;
            r_rd_q  <= RD_n;
            r_wr_q  <= WR_n;
            r_wr_p  <= r_wr_q;
            r_bus_q <= DIR_DATO;
            r_bus_p <= r_bus_q;
        end
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_state <= S_IDLE;
            r_drive <= 1'b0;
            r_addr  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_drive <= 1'b0;
                    // WR wins over RD when both are low
                    if (!r_cs_q && !r_wr_q) begin
                        r_state <= r_ad_q ? S_WRITE : S_ADDR;
                    end else if (!r_cs_q && r_ad_q && !r_rd_q) begin
                        r_state <= S_READ;
                        r_drive <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (r_cs_q) begin
                        r_state <= S_IDLE;
                    end else if (w_wr_rise) begin
                        r_addr  <= r_bus_p;
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (r_cs_q || w_wr_rise)
                        r_state <= S_IDLE;
                end
                S_READ: begin
                    if (r_cs_q || r_rd_q) begin
                        r_state <= S_IDLE;
                        r_drive <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_drive <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_presc  <= '0;
            r_seg    <= 8'h00;
            r_min    <= 8'h00;
            r_hora   <= 8'h00;
            r_dia    <= 8'h00;
            r_mes    <= 8'h00;
            r_ano    <= 8'h00;
            r_segcr  <= 8'h00;
            r_mincr  <= 8'h00;
            r_horacr <= 8'h00;
            r_ctrl   <= 8'h00;
        end else begin
            if (w_wr_en && (r_addr == 8'h21))
                r_presc <= '0;
            else if (!r_ctrl[0])
                r_presc <= (r_presc == TC) ? '0 : r_presc + PW'(1);

            if (w_tick)  r_seg  <= bcd_next(r_seg, 8'h59);
            if (w_c_seg) r_min  <= bcd_next(r_min, 8'h59);
            if (w_c_min) r_hora <= bcd_next(r_hora, 8'h23);

            // Later assignment lets a bus write override the tick on the same register
            if (w_wr_en) begin
                case (r_addr)
                    8'h00:   r_ctrl   <= r_bus_p;
                    8'h21:   r_seg    <= r_bus_p;
                    8'h22:   r_min    <= r_bus_p;
                    8'h23:   r_hora   <= r_bus_p;
                    8'h24:   r_dia    <= r_bus_p;
                    8'h25:   r_mes    <= r_bus_p;
                    8'h26:   r_ano    <= r_bus_p;
                    8'h41:   r_segcr  <= r_bus_p;
                    8'h42:   r_mincr  <= r_bus_p;
                    8'h43:   r_horacr <= r_bus_p;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (r_addr)
            8'h00:   w_rdata = r_ctrl;
            8'h21:   w_rdata = r_seg;
            8'h22:   w_rdata = r_min;
            8'h23:   w_rdata = r_hora;
            8'h24:   w_rdata = r_dia;
            8'h25:   w_rdata = r_mes;
            8'h26:   w_rdata = r_ano;
            8'h41:   w_rdata = r_segcr;
            8'h42:   w_rdata = r_mincr;
            8'h43:   w_rdata = r_horacr;
            default: w_rdata = 8'h00;
        endcase
    end

    assign DIR_DATO = r_drive ? w_rdata : 8'bzzzz_zzzz;
    assign drive_en = r_drive;
    assign addr_q   = r_addr;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: directed table, corner sequences and random bus
// traffic checked against a seconds-level time-of-day model.
module tb_rtc_bus_responder;

    localparam int TD = 4;

    logic reloj = 1'b0;
    logic resetM = 1'b1;
    logic CS_n = 1'b1, AD_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1;
    logic tb_drv = 1'b0;
    logic [7:0] tb_dat = 8'h00;
    wire  [7:0] DIR_DATO;
    logic drive_en;
    logic [7:0] addr_q;

    assign DIR_DATO = tb_drv ? tb_dat : 8'bzzzz_zzzz;

    rtc_bus_responder #(.TICK_DIV(TD)) dut (
        .reloj(reloj), .resetM(resetM), .CS_n(CS_n), .AD_n(AD_n), .RD_n(RD_n),
        .WR_n(WR_n), .DIR_DATO(DIR_DATO), .drive_en(drive_en), .addr_q(addr_q)
    );

    always #5 reloj = ~reloj;

    int cyc = 0;
    always @(posedge reloj) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;

    // reference model: time fields, flat memory for the rest, prescaler phase
    logic [7:0] m_s, m_m, m_h;
    logic [7:0] m_mem [256];
    int m_ref, m_phase;
    bit m_halt;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_v;
    } vec_t;
    vec_t tbl [18];

    logic [7:0] amap [10] = '{8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %02h expected %02h", name, cyc, act, exp_v);
        end
    endtask

    function automatic bit is_mapped(input logic [7:0] a);
        return (a == 8'h00) || (a >= 8'h21 && a <= 8'h26) || (a >= 8'h41 && a <= 8'h43);
    endfunction

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input int maxd, output bit carry);
        int d;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) begin
            carry = 1'b1;
            return 8'h00;
        end
        d = int'(v[7:4]) * 10 + int'(v[3:0]);
        if (d >= maxd) begin
            carry = 1'b1;
            return 8'h00;
        end
        carry = 1'b0;
        d = d + 1;
        return {4'(d / 10), 4'(d % 10)};
    endfunction

    task automatic one_second();
        bit c;
        m_s = wrap_inc(m_s, 59, c);
        if (c) begin
            m_m = wrap_inc(m_m, 59, c);
            if (c) m_h = wrap_inc(m_h, 23, c);
        end
    endtask

    task automatic advance_to(input int e);
        int span;
        if (!m_halt) begin
            span = e - m_ref + m_phase;
            repeat (span / TD) one_second();
            m_phase = span % TD;
        end
        m_ref = e;
    endtask

    task automatic model_reset(input int e);
        m_s = 8'h00; m_m = 8'h00; m_h = 8'h00;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_ref = e; m_phase = 0; m_halt = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [7:0] d, input int e);
        advance_to(e);
        if (a == 8'h21) begin
            m_s = d;
            m_phase = 0;
        end else if (a == 8'h22) m_m = d;
        else if (a == 8'h23) m_h = d;
        else if (is_mapped(a)) m_mem[a] = d;
        if (a == 8'h00) m_halt = d[0];
    endtask

    task automatic model_read(input logic [7:0] a, input int e, output logic [7:0] v);
        advance_to(e);
        if (a == 8'h21) v = m_s;
        else if (a == 8'h22) v = m_m;
        else if (a == 8'h23) v = m_h;
        else v = is_mapped(a) ? m_mem[a] : 8'h00;
    endtask

    // One address or data phase with a 4-cycle WR_n pulse; e is the edge that applies it.
    task automatic bus_phase(input bit is_data, input logic [7:0] v, output int e);
        @(negedge reloj);
        CS_n = 1'b0; AD_n = is_data; WR_n = 1'b0; tb_drv = 1'b1; tb_dat = v;
        repeat (4) @(negedge reloj);
        WR_n = 1'b1;
        e = cyc + 2;
        @(negedge reloj);
        tb_drv = 1'b0;
        repeat (2) @(negedge reloj);
        CS_n = 1'b1; AD_n = 1'b1;
        @(negedge reloj);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        int e;
        bus_phase(1'b0, a, e);
        check("addr_latch", addr_q, a);
        bus_phase(1'b1, d, e);
        model_write(a, d, e);
    endtask

    task automatic bus_read(input logic [7:0] a, input int n, input bit use_exp, input logic [7:0] exp_v);
        int e;
        logic [7:0] want;
        bus_phase(1'b0, a, e);
        check("addr_latch", addr_q, a);
        CS_n = 1'b0; AD_n = 1'b1; RD_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge reloj);
            check("rd_drive", 8'(drive_en), (i >= 1) ? 8'd1 : 8'd0);
            if (drive_en) begin
                if (use_exp) want = exp_v;
                else model_read(a, cyc, want);
                check("rd_data", DIR_DATO, want);
            end
        end
        RD_n = 1'b1;
        @(negedge reloj);
        check("rd_hold", 8'(drive_en), 8'd1);
        @(negedge reloj);
        check("rd_release", 8'(drive_en), 8'd0);
        CS_n = 1'b1;
        @(negedge reloj);
    endtask

    initial begin
        int e;
        logic [7:0] ra, rd, want;

        tbl[0]  = '{1'b0, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 8'h41, 8'h37, 8'h00};
        tbl[2]  = '{1'b0, 8'h41, 8'h00, 8'h37};
        tbl[3]  = '{1'b0, 8'h10, 8'h00, 8'h00};
        tbl[4]  = '{1'b1, 8'h10, 8'hAA, 8'h00};
        tbl[5]  = '{1'b0, 8'h10, 8'h00, 8'h00};
        tbl[6]  = '{1'b0, 8'h41, 8'h00, 8'h37};
        tbl[7]  = '{1'b1, 8'h24, 8'h31, 8'h00};
        tbl[8]  = '{1'b1, 8'h25, 8'h12, 8'h00};
        tbl[9]  = '{1'b1, 8'h26, 8'h99, 8'h00};
        tbl[10] = '{1'b0, 8'h24, 8'h00, 8'h31};
        tbl[11] = '{1'b0, 8'h25, 8'h00, 8'h12};
        tbl[12] = '{1'b0, 8'h26, 8'h00, 8'h99};
        tbl[13] = '{1'b1, 8'h42, 8'h5A, 8'h00};
        tbl[14] = '{1'b1, 8'h43, 8'hFF, 8'h00};
        tbl[15] = '{1'b0, 8'h42, 8'h00, 8'h5A};
        tbl[16] = '{1'b0, 8'h43, 8'h00, 8'hFF};
        tbl[17] = '{1'b0, 8'hFF, 8'h00, 8'h00};

        // reset state
        repeat (3) @(negedge reloj);
        check("rst_drive", 8'(drive_en), 8'd0);
        check("rst_addr", addr_q, 8'h00);
        resetM = 1'b0;
        model_reset(cyc);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
            else bus_read(tbl[i].addr, 8, 1'b1, tbl[i].exp_v);
        end

        // rollover 23:59:59 -> 00:00:00
        bus_write(8'h00, 8'h01);
        bus_write(8'h23, 8'h23);
        bus_write(8'h22, 8'h59);
        bus_write(8'h21, 8'h59);
        bus_write(8'h00, 8'h00);
        bus_read(8'h21, 6, 1'b0, 8'h00);
        bus_read(8'h22, 4, 1'b0, 8'h00);
        bus_read(8'h23, 4, 1'b0, 8'h00);
        bus_read(8'h23, 2, 1'b1, 8'h00);

        // halt, then resume from the held prescaler value
        bus_write(8'h00, 8'h01);
        repeat (3 * TD) @(negedge reloj);
        bus_read(8'h21, 4, 1'b0, 8'h00);
        bus_write(8'h00, 8'h00);
        bus_read(8'h21, 16, 1'b0, 8'h00);

        // abort: CS_n rises while WR_n is low
        bus_write(8'h22, 8'h17);
        bus_phase(1'b0, 8'h22, e);
        CS_n = 1'b0; AD_n = 1'b1; WR_n = 1'b0; tb_drv = 1'b1; tb_dat = 8'h55;
        repeat (4) @(negedge reloj);
        CS_n = 1'b1;
        repeat (2) @(negedge reloj);
        WR_n = 1'b1;
        @(negedge reloj);
        tb_drv = 1'b0;
        repeat (2) @(negedge reloj);
        check("abort_drive", 8'(drive_en), 8'd0);
        bus_read(8'h22, 4, 1'b0, 8'h00);

        // RD and WR low together: write taken, bus never driven
        bus_phase(1'b0, 8'h42, e);
        CS_n = 1'b0; AD_n = 1'b1; RD_n = 1'b0; WR_n = 1'b0; tb_drv = 1'b1; tb_dat = 8'h66;
        for (int i = 0; i < 4; i++) begin
            @(negedge reloj);
            check("prio_undriven", 8'(drive_en), 8'd0);
        end
        RD_n = 1'b1; WR_n = 1'b1;
        e = cyc + 2;
        @(negedge reloj);
        tb_drv = 1'b0;
        check("prio_undriven", 8'(drive_en), 8'd0);
        repeat (2) @(negedge reloj);
        CS_n = 1'b1;
        @(negedge reloj);
        model_write(8'h42, 8'h66, e);
        bus_read(8'h42, 4, 1'b0, 8'h00);

        // reset in the middle of a read of seg
        bus_write(8'h21, 8'h42);
        bus_phase(1'b0, 8'h21, e);
        CS_n = 1'b0; AD_n = 1'b1; RD_n = 1'b0;
        repeat (3) @(negedge reloj);
        check("mid_drive", 8'(drive_en), 8'd1);
        model_read(8'h21, cyc, want);
        check("mid_data", DIR_DATO, want);
        resetM = 1'b1;
        @(negedge reloj);
        check("rst_mid_drive", 8'(drive_en), 8'd0);
        check("rst_mid_addr", addr_q, 8'h00);
        resetM = 1'b0; RD_n = 1'b1; CS_n = 1'b1;
        model_reset(cyc);
        bus_read(8'h21, 4, 1'b0, 8'h00);
        bus_read(8'h41, 3, 1'b1, 8'h00);

        // random traffic against the model
        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = $urandom_range(0, 10);
            ra = (sel < 10) ? amap[sel] : 8'($urandom_range(0, 255));
            rd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) bus_write(ra, rd);
            else bus_read(ra, $urandom_range(2, 6), 1'b0, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Synthesizable responder for the multiplexed address/data RTC bus that the control path drives through `mux_DIR_DATO`. It decodes the active-low CS/AD/RD/WR strobes, latches an address phase, accepts data writes, and drives `DIR_DATO` during reads. It holds a small register file with a self-advancing BCD time-of-day. It replaces the real RTC in FPGA loopback builds and serves as the bus model in control-path benches.

## Interface
- `TICK_DIV`, 100: `reloj` cycles per one-second tick; legal range ≥ 2.
- `reloj`  in  1  system clock; all state changes on its rising edge.
- `resetM`  in  1  reset; synchronous and active-high.
- `CS_n`  in  1  chip select, active low.
- `AD_n`  in  1  phase select: 0 = address phase, 1 = data phase.
- `RD_n`  in  1  read strobe, active low.
- `WR_n`  in  1  write strobe, active low.
- `DIR_DATO`  inout  8  shared address/data bus; tri-stated except while reading.
- `drive_en`  out  1  high while the block drives `DIR_DATO`; for observation.
- `addr_q`  out  8  currently latched address; for observation.

## Operation
- Register sampling: `CS_n`, `AD_n`, `RD_n`, `WR_n` and `DIR_DATO` are registered every cycle into `_q` copies. The previous `_q` values are kept for edge detection. All decisions use the registered values only.
- Register map:
  - Time block: 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 ano.
  - Timer block: 0x41 segcr, 0x42 mincr, 0x43 horacr.
  - 0x00 control.
  - Unmapped reads return 0x00; unmapped writes are ignored.
- FSM states:
  - **IDLE → ADDR** when `CS_n_q`=0, `AD_n_q`=0 and `WR_n_q`=0.
  - **IDLE → WRITE** when `CS_n_q`=0, `AD_n_q`=1 and `WR_n_q`=0.
  - **IDLE → READ** when `CS_n_q`=0, `AD_n_q`=1 and `RD_n_q`=0.
- ADDR: on the registered rising edge of WR_n (prev 0, now 1), `addr_q` takes the bus value sampled in the last low cycle. Return to IDLE.
- WRITE: on the registered WR_n rising edge, the addressed register takes the bus value sampled in the last low cycle. Return to IDLE.
- READ: `drive_en`=1 and `DIR_DATO` = contents of the addressed register, re-evaluated every cycle. Leave to IDLE when `RD_n_q`=1 or `CS_n_q`=1.
- Abort rule: `CS_n_q` going high in ADDR or WRITE returns the FSM to IDLE with no update.
- Priority rule: RD and WR both low in IDLE is illegal. WRITE is taken, and the bus stays undriven.
- Time advance:
  - A prescaler counts 0 .. TICK_DIV-1. At terminal count, seg increments in BCD.
  - 0x59 → 0x00 carries to min; min 0x59 → 0x00 carries to hora; hora 0x23 → 0x00.
  - dia/mes/ano and the timer block do not auto-advance.
- A bus write to 0x21 clears the prescaler.
- A tick and a bus write to the same time register in the same cycle: the write wins, and the carry into higher registers is still applied.
- Control bit 0 = 1 halts the tick; the prescaler holds its value.

## Timing
- Reset values: `drive_en`=0, `DIR_DATO`=Z, `addr_q`=0x00, all registers 0x00, prescaler 0, FSM IDLE.
- Reset mid-operation: the bus is released on the same edge that samples `resetM`=1. Any pending write is discarded.
- Write latency: WR_n rises before edge N; it is seen in `_q` at edge N; the register updates at edge N+1.
- Read latency: RD_n falls before edge N, so `drive_en`=1 after edge N+1. RD_n rises before edge M, so `drive_en`=0 after edge M+1. The block therefore drives for at most one cycle after the strobe rises.
- Minimum strobe low width: 2 `reloj` cycles. The control path's 32-cycle phases meet this with margin.
- Tick: seg changes exactly every TICK_DIV cycles after reset or after a write to 0x21.
- Arithmetic: the prescaler is $clog2(TICK_DIV) bits wide. BCD nibbles are never allowed to exceed 9. Out-of-range written values are stored as-is, and the next tick wraps them to 0x00 with carry.

## Test plan
- **Address + write + read of 0x41:**
  - Stimulus: address phase on 0x41 (4-cycle WR pulse); write phase 0x37; read phase of 8 cycles.
  - Required: `addr_q`=0x41; `DIR_DATO`=0x37 while `drive_en`=1; bus Z one cycle after RD_n rises.
- **Tick rollover:**
  - Stimulus: TICK_DIV=4; write hora=0x23, min=0x59, seg=0x59; wait 4 cycles.
  - Required: seg=0x00, min=0x00, hora=0x00.
- **Unmapped address:**
  - Stimulus: read of 0x10, then write 0xAA to 0x10.
  - Required: read returns 0x00; all mapped registers unchanged.
- **Abort:**
  - Stimulus: CS_n rises while WR_n is still low during a write of 0x55 to 0x22.
  - Required: min unchanged; FSM back in IDLE.
- **Reset mid-read:**
  - Stimulus: assert `resetM` for 1 cycle during a read of 0x21.
  - Required: `drive_en`=0 on that edge; `DIR_DATO`=Z; seg=0x00.
- **Halt:**
  - Stimulus: write control=0x01; wait 3×TICK_DIV cycles.
  - Required: seg unchanged; after writing control=0x00, seg increments after TICK_DIV − held prescaler value cycles.
